// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square
// wave in clk cycles, and flags when the input stops toggling.
// Optional build macro: GLITCH_FILTER_EN inserts a counter-based glitch filter
// between the synchroniser and the edge detector.
module period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 200_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             timeout,
    output logic             locked
);

    // Elaboration-time parameter sanity checks.
    if ($clog2(TIMEOUT + 1) > CNT_W) begin : g_bad_timeout
        $error("period_meter: TIMEOUT does not fit in CNT_W bits");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("period_meter: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("period_meter: FILTER_LEN must be at least 1");
    end

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    logic [1:0]             rst_pipe;
    logic                   rst_n_int;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s;
    logic                   sig_lvl;
    logic                   sig_d;
    logic                   rise;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hi_cnt;

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n_int = rst_pipe[1];

    // Multi-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
    assign sig_s = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    logic [FW-1:0] flt_cnt;
    logic          sig_f;

    // Accept a new level only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            flt_cnt <= '0;
            sig_f   <= 1'b0;
        end else if (sig_s == sig_f) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_LAST) begin
            sig_f   <= sig_s;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end
    assign sig_lvl = sig_f;
`else
    assign sig_lvl = sig_s;
`endif

    // One-cycle history of the accepted level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) sig_d <= 1'b0;
        else            sig_d <= sig_lvl;
    end
    assign rise = sig_lvl & ~sig_d;

    // Measurement FSM with registered outputs. The rise cycle itself is high,
    // so hi_cnt restarts at one and meas_high can never exceed meas_period.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_cnt      <= '0;
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            timeout     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // First edge after reset or timeout only starts a period.
                    if (rise) begin
                        state   <= MEASURE;
                        locked  <= 1'b1;
                        timeout <= 1'b0;
                        cnt     <= '0;
                        hi_cnt  <= ONE;
                    end
                end
                MEASURE: begin
                    // A rise on the last allowed cycle still counts as a valid period.
                    if (rise) begin
                        meas_valid  <= 1'b1;
                        meas_period <= cnt + ONE;
                        meas_high   <= hi_cnt;
                        cnt         <= '0;
                        hi_cnt      <= ONE;
                        timeout     <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                        if (sig_lvl) hi_cnt <= hi_cnt + ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed testbench for period_meter (TIMEOUT=64, SYNC_STAGES=2, FILTER_LEN=4).
module tb_period_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 64;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             sig_in  = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             timeout;
    logic             locked;

    int pass_cnt  = 0;
    int check_cnt = 0;

    int               cyc = 0;
    int               last_valid_cyc = 0;
    int               to_rise_cyc = 0;
    logic             to_prev = 1'b0;
    logic [CNT_W-1:0] q_per[$];
    logic [CNT_W-1:0] q_hi[$];

    period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(2),
        .FILTER_LEN (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .meas_valid (meas_valid),
        .meas_period(meas_period),
        .meas_high  (meas_high),
        .timeout    (timeout),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every measurement pulse and the cycle timeout rises, sampled mid-cycle.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            q_per.push_back(meas_period);
            q_hi.push_back(meas_high);
            last_valid_cyc = cyc;
        end
        if (timeout === 1'b1 && to_prev !== 1'b1) to_rise_cyc = cyc;
        to_prev = timeout;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    // Drive low until the meter drops out of MEASURE, then empty the pulse log.
    task automatic settle();
        int k = 0;
        sig_in = 1'b0;
        while (locked !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_cnt++;
        if (locked !== 1'b0) $display("FAIL settle: locked=%b after %0d cycles, required 0", locked, k);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        q_per.delete();
        q_hi.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sig_in  = 1'b0;
        repeat (3) @(negedge clk);
        check_cnt++;
        if ({meas_valid, timeout, locked} !== 3'b000)
            $display("FAIL reset_flags: valid/timeout/locked=%b, required 000", {meas_valid, timeout, locked});
        else pass_cnt++;
        check_cnt++;
        if (meas_period !== '0 || meas_high !== '0)
            $display("FAIL reset_values: period=%0d high=%0d, required 0/0", meas_period, meas_high);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_cnt++;
        if ({meas_valid, timeout, locked} !== 3'b000)
            $display("FAIL post_reset_flags: valid/timeout/locked=%b, required 000", {meas_valid, timeout, locked});
        else pass_cnt++;
    endtask

    task automatic test_square();
        settle();
        wave(5, 5, 4);
        #1;
        check_cnt++;
        if (q_per.size() != 3) $display("FAIL square_count: pulses=%0d, required 3", q_per.size());
        else pass_cnt++;
        for (int i = 0; i < q_per.size(); i++) begin
            check_cnt++;
            if (q_per[i] !== 32'd10 || q_hi[i] !== 32'd5)
                $display("FAIL square_meas[%0d]: %0d/%0d, required 10/5", i, q_per[i], q_hi[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (locked !== 1'b1) $display("FAIL square_locked: locked=%b, required 1", locked);
        else pass_cnt++;
    endtask

    task automatic test_duty();
        settle();
        wave(3, 7, 4);
        #1;
        check_cnt++;
        if (q_per.size() != 3) $display("FAIL duty_count: pulses=%0d, required 3", q_per.size());
        else pass_cnt++;
        for (int i = 0; i < q_per.size(); i++) begin
            check_cnt++;
            if (q_per[i] !== 32'd10 || q_hi[i] !== 32'd3)
                $display("FAIL duty_meas[%0d]: %0d/%0d, required 10/3", i, q_per[i], q_hi[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (timeout !== 1'b0) $display("FAIL duty_timeout: timeout=%b, required 0", timeout);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int k = 0;
        settle();
        wave(5, 5, 3);
        while (timeout !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        #1;
        check_cnt++;
        if (timeout !== 1'b1 || locked !== 1'b0)
            $display("FAIL timeout_flags: timeout=%b locked=%b, required 1/0", timeout, locked);
        else pass_cnt++;
        check_cnt++;
        if (to_rise_cyc - last_valid_cyc != TIMEOUT)
            $display("FAIL timeout_delay: %0d cycles after last rise, required %0d", to_rise_cyc - last_valid_cyc, TIMEOUT);
        else pass_cnt++;
        check_cnt++;
        if (q_per.size() != 2 || meas_period !== 32'd10 || meas_high !== 32'd5)
            $display("FAIL timeout_hold: pulses=%0d outputs=%0d/%0d, required 2 pulses and 10/5", q_per.size(), meas_period, meas_high);
        else pass_cnt++;
        q_per.delete();
        q_hi.delete();
        wave(5, 5, 1);
        #1;
        check_cnt++;
        if (timeout !== 1'b0 || locked !== 1'b1 || q_per.size() != 0)
            $display("FAIL timeout_relock: timeout=%b locked=%b pulses=%0d, required 0/1/0", timeout, locked, q_per.size());
        else pass_cnt++;
        wave(5, 5, 1);
        #1;
        check_cnt++;
        if (q_per.size() != 1) $display("FAIL timeout_second_count: pulses=%0d, required 1", q_per.size());
        else if (q_per[0] !== 32'd10 || q_hi[0] !== 32'd5)
            $display("FAIL timeout_second_meas: %0d/%0d, required 10/5", q_per[0], q_hi[0]);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
`ifdef GLITCH_FILTER_EN
        int exp_p[$] = '{20, 20, 20, 20};
        int exp_h[$] = '{10, 10, 10, 10};
`else
        int exp_p[$] = '{20, 20, 14, 6, 20};
        int exp_h[$] = '{10, 10, 10, 1, 10};
`endif
        settle();
        wave(10, 10, 2);
        sig_in = 1'b1; repeat (10) @(negedge clk);
        sig_in = 1'b0; repeat (4) @(negedge clk);
        sig_in = 1'b1; repeat (1) @(negedge clk);
        sig_in = 1'b0; repeat (5) @(negedge clk);
        wave(10, 10, 2);
        #1;
        check_cnt++;
        if (q_per.size() != exp_p.size())
            $display("FAIL glitch_count: pulses=%0d, required %0d", q_per.size(), exp_p.size());
        else pass_cnt++;
        for (int i = 0; i < q_per.size() && i < exp_p.size(); i++) begin
            check_cnt++;
            if (q_per[i] !== CNT_W'(exp_p[i]) || q_hi[i] !== CNT_W'(exp_h[i]))
                $display("FAIL glitch_meas[%0d]: %0d/%0d, required %0d/%0d", i, q_per[i], q_hi[i], exp_p[i], exp_h[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        settle();
        wave(5, 5, 2);
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        check_cnt++;
        if (meas_period !== 32'd10) $display("FAIL midrst_pre: period=%0d, required 10", meas_period);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        check_cnt++;
        if ({meas_valid, timeout, locked} !== 3'b000 || meas_period !== '0 || meas_high !== '0)
            $display("FAIL midrst_async: flags=%b period=%0d high=%0d, required 000/0/0",
                     {meas_valid, timeout, locked}, meas_period, meas_high);
        else pass_cnt++;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        q_per.delete();
        q_hi.delete();
        wave(3, 5, 2);
        #1;
        check_cnt++;
        if (q_per.size() != 1) $display("FAIL midrst_count: pulses=%0d, required 1", q_per.size());
        else if (q_per[0] !== 32'd8 || q_hi[0] !== 32'd3)
            $display("FAIL midrst_meas: %0d/%0d, required 8/3", q_per[0], q_hi[0]);
        else pass_cnt++;
    endtask

    task automatic test_coincide();
        settle();
        wave(10, TIMEOUT - 10, 2);
        sig_in = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check_cnt++;
        if (q_per.size() != 2) $display("FAIL coincide_count: pulses=%0d, required 2", q_per.size());
        else pass_cnt++;
        for (int i = 0; i < q_per.size(); i++) begin
            check_cnt++;
            if (q_per[i] !== CNT_W'(TIMEOUT) || q_hi[i] !== 32'd10)
                $display("FAIL coincide_meas[%0d]: %0d/%0d, required %0d/10", i, q_per[i], q_hi[i], TIMEOUT);
            else pass_cnt++;
        end
        check_cnt++;
        if (timeout !== 1'b0 || locked !== 1'b1)
            $display("FAIL coincide_flags: timeout=%b locked=%b, required 0/1", timeout, locked);
        else pass_cnt++;
        sig_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_coincide();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
